// File: rtl/lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lane_scheduler
// Purpose  : Frogger lane controller. Paces each car lane with its own step
//            period, detects frog/car collisions, and tracks lives and level.
// Revision : 1.0 - initial release
// ============================================================================
module lane_scheduler #(
    parameter int NUM_LANES   = 4,
    parameter int BASE_PERIOD = 256,
    parameter int LEVEL_DEC   = 16,
    parameter int LANE_DEC    = 8,
    parameter int MAX_LEVEL   = 7,
    parameter int HOLD_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [2:0]              frog_row,
    input  logic [3:0]              frog_col,
    input  logic [16*NUM_LANES-1:0] lane_pixels,
    output logic [NUM_LANES-1:0]    step,
    output logic [NUM_LANES-1:0]    dir,
    output logic                    hit,
    output logic                    level_up,
    output logic [2:0]              level,
    output logic [1:0]              lives,
    output logic                    playing,
    output logic                    game_over,
    output logic                    win
);

    localparam int CW = $clog2(BASE_PERIOD);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_OVER = 2'd3;

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [HW-1:0] r_hold_cnt;
    logic          w_in_lane;
    logic          w_cell;
    logic          w_collide;
    logic          w_goal;
    logic          w_hit_n;
    logic          w_level_up_n;
    logic [1:0]    w_lives_n;
    logic [2:0]    w_level_n;
    logic          w_win_n;
    logic          w_clear;
    logic          w_run;

    // Reset asserts immediately, releases two clock edges later
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // Look up the pixel under the frog when it stands in a lane row
    always_comb begin
        w_in_lane = 1'b0;
        w_cell    = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (frog_row == 3'(i + 1)) begin
                w_in_lane = 1'b1;
                w_cell    = lane_pixels[16*i + frog_col];
            end
        end
    end
    assign w_collide = w_in_lane && w_cell;
    assign w_goal    = (frog_row == 3'(NUM_LANES + 1));

    // State register
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state decision
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_OVER: if (start) w_state_next = S_PLAY;
            S_PLAY: begin
                if (w_collide)
                    w_state_next = (lives > 2'd1) ? S_HOLD : S_OVER;
                else if (w_goal)
                    w_state_next = (level < 3'(MAX_LEVEL)) ? S_HOLD : S_OVER;
            end
            S_HOLD: if (r_hold_cnt == HW'(HOLD_CYCLES - 1)) w_state_next = S_PLAY;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Next values of the game outputs; counters restart on every HOLD entry
    always_comb begin
        w_hit_n      = 1'b0;
        w_level_up_n = 1'b0;
        w_lives_n    = lives;
        w_level_n    = level;
        w_win_n      = win;
        w_clear      = 1'b0;
        w_run        = (r_state == S_PLAY);
        case (r_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    w_lives_n = 2'd3;
                    w_level_n = 3'd0;
                    w_win_n   = 1'b0;
                    w_clear   = 1'b1;
                end
            end
            S_PLAY: begin
                if (w_collide) begin
                    w_hit_n   = 1'b1;
                    w_lives_n = lives - 2'd1;
                    w_clear   = 1'b1;
                    if (lives <= 2'd1) w_win_n = 1'b0;
                end else if (w_goal) begin
                    if (level < 3'(MAX_LEVEL)) begin
                        w_level_n    = level + 3'd1;
                        w_level_up_n = 1'b1;
                        w_clear      = 1'b1;
                    end else begin
                        w_win_n = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Registered game outputs and hold timer
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_hold_cnt <= '0;
            hit        <= 1'b0;
            level_up   <= 1'b0;
            lives      <= 2'd3;
            level      <= 3'd0;
            win        <= 1'b0;
            playing    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            r_hold_cnt <= (r_state == S_HOLD) ? r_hold_cnt + 1'b1 : '0;
            hit        <= w_hit_n;
            level_up   <= w_level_up_n;
            lives      <= w_lives_n;
            level      <= w_level_n;
            win        <= w_win_n;
            playing    <= (w_state_next == S_PLAY);
            game_over  <= (w_state_next == S_OVER);
        end
    end

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [CW-1:0] r_cnt;
        logic          r_step;
        logic [CW-1:0] w_last;

        assign w_last   = CW'(BASE_PERIOD - LEVEL_DEC*int'(level) - LANE_DEC*gi - 1);
        assign dir[gi]  = ((gi % 2) == 1);
        assign step[gi] = r_step;

        // Lane period counter; a step still fires on the edge that clears it
        always_ff @(posedge clk or negedge w_rst_n) begin
            if (!w_rst_n) begin
                r_cnt  <= '0;
                r_step <= 1'b0;
            end else begin
                r_step <= w_run && (r_cnt == w_last);
                if (w_clear)
                    r_cnt <= '0;
                else if (w_run)
                    r_cnt <= (r_cnt == w_last) ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
